// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int IF_ADDR_W  = 12;
    localparam int IF_INSTR_W = 32;
    localparam int IF_DEPTH   = 4;

    // Queue entry at the default widths; the top builds the same layout from its parameters.
    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous instruction queue with flush, occupancy count and full/empty flags.
module if_fetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A flush wins over any push or pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Next pointer and occupancy values.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage.
    // NOTE: the data array has no reset; validity is tracked by count_q alone, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointer and occupancy registers.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC sequencing, redirect/halt control, credit-limited
// memory requests and an instruction queue toward decode.
module if_fetch
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INSTR_W  = IF_INSTR_W,
    parameter int                DEPTH    = IF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               id_valid_o,
    input  logic               id_ready_i,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0]  id_pc_o,
    output logic [ADDR_W-1:0]  id_pc_plus1_o
);

    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  q_count;
    logic              q_full, q_empty;
    logic              credit_ok, req_acc, push, pop;
    entry_t            push_entry, head_entry;

    // Every queue slot is reserved at request time, including requests whose data will be dropped.
    assign credit_ok = (outstanding_q + q_count) < DEPTH_CNT;
    assign req_acc   = imem_req_o && imem_gnt_i;
    assign push      = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign pop       = id_valid_o && id_ready_i;

    // Halt FSM and request generation; a raised but ungranted request holds off the halt.
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_o = credit_ok && !rst;
                if (halt_i && !(imem_req_o && !imem_gnt_i)) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt_i) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // PC, in-flight and discard bookkeeping; a redirect retargets both PCs and marks all in-flight data stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_acc) - CNT_W'(imem_rvalid_i);
        discard_d     = discard_q;
        if (req_acc) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        if (push)    resp_pc_d  = resp_pc_q + ADDR_W'(1);
        if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            // Everything still in flight after this cycle belongs to the old stream.
            discard_d  = outstanding_d;
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

    if_fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // The credit check must make a push into a full, non-draining queue impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));

    assign imem_addr_o   = fetch_pc_q;
    assign id_valid_o    = !q_empty;
    assign id_instr_o    = head_entry.instr;
    assign id_pc_o       = head_entry.pc;
    assign id_pc_plus1_o = head_entry.pc + ADDR_W'(1);

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a default 12-bit instance exercised through
// stream, backpressure, redirect, halt and reset phases, plus a 4-bit instance
// starting near the top of the address space to check PC wrap.
module tb_if_fetch;

    typedef struct {
        logic [11:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [3:0] addr;
        int         due;
    } pend_b_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        req;
    logic [11:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [11:0] id_pc;
    logic [11:0] id_pc_plus1;

    logic        rst_b = 1'b1;
    logic        req_b;
    logic [3:0]  addr_b;
    logic        rvalid_b = 1'b0;
    logic [31:0] rdata_b = '0;
    logic        id_valid_b;
    logic [31:0] id_instr_b;
    logic [3:0]  id_pc_b;
    logic [3:0]  id_pc_plus1_b;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 2;
    logic        gnt_en = 1'b1;
    int          grant_cnt = 0;
    pend_t       pend_q[$];
    pend_b_t     pend_b_q[$];
    logic [11:0] exp_q[$];
    logic [3:0]  exp_b_q[$];

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk           (clk),
        .rst           (rst),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .id_valid_o    (id_valid),
        .id_ready_i    (id_ready),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .id_pc_plus1_o (id_pc_plus1)
    );

    if_fetch #(.ADDR_W(4), .INSTR_W(32), .DEPTH(4), .RESET_PC(4'd14)) u_dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .halt_i        (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (4'd0),
        .imem_req_o    (req_b),
        .imem_addr_o   (addr_b),
        .imem_gnt_i    (1'b1),
        .imem_rvalid_i (rvalid_b),
        .imem_rdata_i  (rdata_b),
        .id_valid_o    (id_valid_b),
        .id_ready_i    (1'b1),
        .id_instr_o    (id_instr_b),
        .id_pc_o       (id_pc_b),
        .id_pc_plus1_o (id_pc_plus1_b)
    );

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {8'hC3, a ^ 12'h5A5, a};
    endfunction

    function automatic logic [31:0] mem_word_b(input logic [3:0] a);
        return {28'hB0B0B0B, a};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory for the main instance: fixed latency, in-order responses.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (rst) begin
                pend_q.delete();
                gnt    = 1'b0;
                rvalid = 1'b0;
            end else begin
                rvalid = 1'b0;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end
                gnt = gnt_en;
                if (req && gnt) begin
                    pend_t p;
                    p.addr = addr;
                    p.due  = cyc + lat;
                    pend_q.push_back(p);
                    grant_cnt++;
                end
            end
        end
    end

    // Instruction memory for the narrow instance: always grants, one-cycle latency.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_b) begin
                pend_b_q.delete();
                rvalid_b = 1'b0;
            end else begin
                rvalid_b = 1'b0;
                if (pend_b_q.size() > 0 && pend_b_q[0].due <= cyc) begin
                    rvalid_b = 1'b1;
                    rdata_b  = mem_word_b(pend_b_q[0].addr);
                    void'(pend_b_q.pop_front());
                end
                if (req_b) begin
                    pend_b_t p;
                    p.addr = addr_b;
                    p.due  = cyc + 1;
                    pend_b_q.push_back(p);
                end
            end
        end
    end

    // Monitor: every accepted decode handshake is compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_extra: popped pc 0x%0h, expected no entry", id_pc);
                end else begin
                    logic [11:0] e, e1;
                    e  = exp_q.pop_front();
                    e1 = e + 12'd1;
                    check("sb_pc", id_pc, e);
                    check("sb_instr", id_instr, mem_word(e));
                    check("sb_pc_plus1", id_pc_plus1, e1);
                end
            end
            if (!rst_b && id_valid_b && exp_b_q.size() > 0) begin
                logic [3:0] eb, eb1;
                eb  = exp_b_q.pop_front();
                eb1 = eb + 4'd1;
                check("b_sb_pc", id_pc_b, eb);
                check("b_sb_instr", id_instr_b, mem_word_b(eb));
                check("b_sb_pc_plus1", id_pc_plus1_b, eb1);
            end
        end
    end

    // Directed stimulus.
    initial begin
        for (int i = 0; i < 10; i++) exp_q.push_back(12'(i));
        for (int i = 0; i < 16; i++) exp_b_q.push_back(4'(14 + i));

        repeat (3) next_cycle();
        check("rst_req", req, 1'b0);
        check("rst_valid", id_valid, 1'b0);
        check("rst_addr", addr, 12'h000);

        // Stream: gnt always, latency 2, decode always ready.
        rst   = 1'b0;
        rst_b = 1'b0;
        #1;
        check("first_req", req, 1'b1);
        check("first_addr", addr, 12'h000);
        check("b_first_addr", addr_b, 4'd14);
        next_cycle();
        next_cycle();
        check("fill_valid_c2", id_valid, 1'b0);
        next_cycle();
        check("fill_valid_c3", id_valid, 1'b1);
        check("fill_pc_c3", id_pc, 12'h000);
        repeat (6) next_cycle();
        halt = 1'b1;
        next_cycle();
        check("halt_req_off", req, 1'b0);
        repeat (6) next_cycle();
        check("a_drained_valid", id_valid, 1'b0);
        check("a_drained_sb", exp_q.size(), 0);

        // Backpressure: four grants fill the credit, then issue resumes on ready.
        for (int i = 10; i < 17; i++) exp_q.push_back(12'(i));
        id_ready  = 1'b0;
        halt      = 1'b0;
        grant_cnt = 0;
        next_cycle();
        check("b_resume_req", req, 1'b1);
        check("b_resume_addr", addr, 12'd10);
        repeat (7) next_cycle();
        check("bp_grants", grant_cnt, 4);
        check("bp_req_off", req, 1'b0);
        check("bp_head_pc", id_pc, 12'd10);
        id_ready = 1'b1;
        repeat (3) next_cycle();
        halt = 1'b1;
        next_cycle();
        check("bp_total_grants", grant_cnt, 7);
        repeat (8) next_cycle();
        check("bp_drained_sb", exp_q.size(), 0);

        // Redirect with three in flight and a response in the same cycle.
        for (int i = 0; i < 3; i++) exp_q.push_back(12'h100 + 12'(i));
        lat  = 4;
        halt = 1'b0;
        repeat (4) next_cycle();
        gnt_en = 1'b0;
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 12'h100;
        next_cycle();
        redirect = 1'b0;
        gnt_en   = 1'b1;
        check("redir_addr", addr, 12'h100);
        check("redir_req", req, 1'b1);
        check("redir_flushed", id_valid, 1'b0);
        repeat (2) next_cycle();
        halt = 1'b1;
        repeat (9) next_cycle();
        check("redir_drained_sb", exp_q.size(), 0);

        // Halt raised while a request waits for its grant.
        exp_q.push_back(12'h103);
        exp_q.push_back(12'h104);
        lat    = 2;
        halt   = 1'b0;
        gnt_en = 1'b0;
        next_cycle();
        halt = 1'b1;
        check("hold_req_1", req, 1'b1);
        check("hold_addr_1", addr, 12'h103);
        next_cycle();
        check("hold_req_2", req, 1'b1);
        check("hold_addr_2", addr, 12'h103);
        next_cycle();
        gnt_en = 1'b1;
        next_cycle();
        check("hold_req_off", req, 1'b0);
        repeat (4) next_cycle();
        check("hold_drained_valid", id_valid, 1'b0);
        halt = 1'b0;
        next_cycle();
        check("hold_seq_addr", addr, 12'h104);
        check("hold_seq_req", req, 1'b1);
        halt = 1'b1;
        next_cycle();
        check("hold_req_off_2", req, 1'b0);
        repeat (5) next_cycle();

        // Redirect while halted: PC moves, state stays halted.
        exp_q.push_back(12'h200);
        redirect    = 1'b1;
        redirect_pc = 12'h200;
        next_cycle();
        redirect = 1'b0;
        check("halted_redir_req", req, 1'b0);
        halt = 1'b0;
        next_cycle();
        check("halted_redir_addr", addr, 12'h200);
        check("halted_redir_req_on", req, 1'b1);
        halt = 1'b1;
        repeat (6) next_cycle();
        check("halted_redir_sb", exp_q.size(), 0);

        // Reset in the middle of a burst.
        exp_q.push_back(12'h201);
        halt = 1'b0;
        repeat (5) next_cycle();
        check("burst_req", req, 1'b1);
        check("burst_valid", id_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_req", req, 1'b0);
        check("midrst_valid", id_valid, 1'b0);
        repeat (2) next_cycle();
        check("midrst_sb", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(12'(i));
        rst = 1'b0;
        #1;
        check("restart_req", req, 1'b1);
        check("restart_addr", addr, 12'h000);
        repeat (2) next_cycle();
        halt = 1'b1;
        repeat (8) next_cycle();

        check("end_sb_empty", exp_q.size(), 0);
        check("end_b_sb_empty", exp_b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
